// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_pkg                                               |
// | Description : Shared Gray-code conversion helpers and the chunk      |
// |               size used to split the gray-to-binary XOR chain.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gray_pkg;

  localparam int C_MAX_WIDTH = 32;

  // Bits of the gray-to-binary chain resolved by one pipeline stage.
  function automatic int chunk_f(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Resolve bits hi..lo of a partially converted word. Bits above hi must
  // already be binary; bits above the word width must be zero.
  function automatic logic [C_MAX_WIDTH-1:0] gray2bin_range_f(
    input logic [C_MAX_WIDTH-1:0] d,
    input int                     hi,
    input int                     lo
  );
    logic [C_MAX_WIDTH-1:0] r;
    r = d;
    for (int i = C_MAX_WIDTH - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) begin
        r[i] = r[i+1] ^ r[i];
      end
    end
    return r;
  endfunction

  // Full gray-to-binary conversion of a zero-extended word.
  function automatic logic [C_MAX_WIDTH-1:0] gray2bin_f(input logic [C_MAX_WIDTH-1:0] g);
    return gray2bin_range_f(g, C_MAX_WIDTH - 1, 0);
  endfunction

  // Binary-to-gray conversion.
  function automatic logic [C_MAX_WIDTH-1:0] bin2gray_f(input logic [C_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_conv_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_conv_stage                                        |
// | Description : One pipeline step. Resolves its MSB-first chunk of the |
// |               gray-to-binary chain, or (stage 0 only) finishes a     |
// |               binary-to-gray word; later stages pass b2g unchanged.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             prev_valid,
  input  logic             prev_mode,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data
);

  localparam int C_CHUNK = chunk_f(WIDTH, STAGES);
  localparam int C_HI    = WIDTH - 1 - IDX * C_CHUNK;
  localparam int C_LO    = C_HI - C_CHUNK + 1;

  logic [WIDTH-1:0] w_next;

  // Conversion work done by this stage on the incoming word.
  always_comb begin
    w_next = prev_data;
    if (prev_mode) begin
      if (IDX == 0) begin
        w_next = WIDTH'(bin2gray_f(32'(prev_data)));
      end
    end else begin
      // Bit C_HI+1 was resolved upstream (or is the zero extension).
      w_next = WIDTH'(gray2bin_range_f(32'(prev_data), C_HI, C_LO));
    end
  end

  // Stage register: valid, mode and data move together when loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= prev_valid;
      mode  <= prev_mode;
      data  <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_conv_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_conv_pipe                                         |
// | Description : Valid/ready pipelined Gray<->binary converter with a   |
// |               per-word mode bit and an output handshake counter.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gray_conv_pipe #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      out_cnt
);

  // Index 0 is the pipe input; index s+1 is the register of stage s.
  logic [STAGES:0]  w_vld;
  logic [STAGES:0]  w_md;
  logic [WIDTH-1:0] w_dat [STAGES+1];
  logic [STAGES-1:0] w_load;

  assign w_vld[0] = in_valid;
  assign w_md[0]  = in_mode;
  assign w_dat[0] = in_data;

  // Backward load chain: a stage loads when empty or when its successor loads.
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = !w_vld[STAGES] || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      w_load[s] = !w_vld[s+1] || w_load[s+1];
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_vld[STAGES];
  assign out_mode  = w_md[STAGES];
  assign out_data  = w_dat[STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    gray_conv_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (s)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_load[s]),
      .prev_valid (w_vld[s]),
      .prev_mode  (w_md[s]),
      .prev_data  (w_dat[s]),
      .valid      (w_vld[s+1]),
      .mode       (w_md[s+1]),
      .data       (w_dat[s+1])
    );
  end

  // Completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gray_conv_pipe                                      |
// | Description : Self-checking bench: queue-based reference model with  |
// |               per-cycle compare plus directed literal checks, and   |
// |               three WIDTH=8 instances for latency and round trip.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gray_conv_pipe;

  localparam int W = 5;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic         out_mode;
  logic [W-1:0] out_data;
  logic [15:0]  out_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_conv_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  // WIDTH=8 instances with STAGES = 1, 3, 8
  logic       w8_valid = 1'b0;
  logic       w8_mode  = 1'b0;
  logic [7:0] w8_data  = '0;
  logic       w8_ir  [3];
  logic       w8_ov  [3];
  logic       w8_om  [3];
  logic [7:0] w8_od  [3];
  logic [15:0] w8_cnt [3];

  for (genvar k = 0; k < 3; k++) begin : g_w8
    gray_conv_pipe #(.WIDTH(8), .STAGES(k == 0 ? 1 : (k == 1 ? 3 : 8))) u_w8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w8_valid),
      .in_ready  (w8_ir[k]),
      .in_mode   (w8_mode),
      .in_data   (w8_data),
      .out_valid (w8_ov[k]),
      .out_ready (1'b1),
      .out_mode  (w8_om[k]),
      .out_data  (w8_od[k]),
      .out_cnt   (w8_cnt[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference conversions written from the arithmetic definition.
  function automatic logic [31:0] g2b_m(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [31:0] b2g_m(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- scoreboard for the main instance ----------------
  int           cyc = 0;
  logic         chk_en = 1'b0;
  logic         exp_ir = 1'b1;
  logic         exp_ov = 1'b0;
  logic [15:0]  mcnt = '0;
  int           q_acc [$];
  logic [W-1:0] q_dat [$];
  logic         q_md  [$];

  // The head word reaches the output STAGES-1 edges after its accepting edge
  // and stays there until taken; the pipe stalls input only when full.
  always @(negedge clk) begin
    exp_ir = (q_dat.size() < S) || out_ready;
    exp_ov = 1'b0;
    if (q_dat.size() > 0) exp_ov = (cyc - q_acc[0] >= S - 1);
    if (chk_en) begin
      chk("sb_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("sb_out_valid", 32'(out_valid), 32'(exp_ov));
      chk("sb_out_cnt", 32'(out_cnt), 32'(mcnt));
      if (exp_ov) begin
        chk("sb_out_data", 32'(out_data), 32'(q_dat[0]));
        chk("sb_out_mode", 32'(out_mode), 32'(q_md[0]));
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q_acc.delete();
      q_dat.delete();
      q_md.delete();
      mcnt = '0;
    end else begin
      if (exp_ov && out_ready) begin
        void'(q_acc.pop_front());
        void'(q_dat.pop_front());
        void'(q_md.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (in_valid && exp_ir) begin
        q_acc.push_back(cyc);
        q_md.push_back(in_mode);
        q_dat.push_back(in_mode ? W'(b2g_m(32'(in_data))) : W'(g2b_m(32'(in_data))));
      end
    end
  end

  // ---------------- WIDTH=8 helpers ----------------
  int         lat8 [3];
  logic [7:0] res8 [3];
  logic       md8  [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic w8_send(input logic m, input logic [7:0] d);
    for (int k = 0; k < 3; k++) begin
      lat8[k] = 0;
      res8[k] = '0;
      md8[k]  = 1'b0;
    end
    w8_valid = 1'b1;
    w8_mode  = m;
    w8_data  = d;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("w8_in_ready", 32'(w8_ir[k]), 32'd1);
    step();
    w8_valid = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (w8_ov[k] && lat8[k] == 0) begin
          lat8[k] = e;
          res8[k] = w8_od[k];
          md8[k]  = w8_om[k];
        end
      end
      step();
    end
  endtask

  function automatic int w8_stages(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
  endfunction

  // Time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] x;
    logic [7:0] g;

    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the reference model with hand-computed values.
    chk("pin_g2b", g2b_m(32'b11010), 32'b10011);
    chk("pin_b2g", b2g_m(32'b10011), 32'b11010);
    chk("pin_g2b_7", g2b_m(32'b00111), 32'b00101);

    // Single gray-to-binary word: visible two edges after acceptance.
    step();
    in_valid = 1'b1; in_mode = 1'b0; in_data = 5'b11010;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("g2b_early_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("g2b_valid", 32'(out_valid), 32'd1);
    chk("g2b_11010", 32'(out_data), 32'b10011);
    repeat (2) step();

    // Single binary-to-gray word.
    in_valid = 1'b1; in_mode = 1'b1; in_data = 5'b10011;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("b2g_valid", 32'(out_valid), 32'd1);
    chk("b2g_10011", 32'(out_data), 32'b11010);
    chk("b2g_mode", 32'(out_mode), 32'd1);
    repeat (2) step();

    // All 32 values back-to-back with alternating modes.
    for (int v = 0; v < 32; v++) begin
      in_valid = 1'b1; in_mode = v[0]; in_data = W'(v);
      @(negedge clk);
      chk("thru_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure: output stalled for 5 cycles under a continuous stream.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mode = i[0]; in_data = W'(7 + 3 * i);
      if (i == 2) begin
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      if (i == 4) begin
        @(negedge clk);
        chk("bp_head_held", 32'(out_data), 32'b00101);
        chk("bp_head_valid", 32'(out_valid), 32'd1);
      end
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (6) step();

    // Reset with two words in flight.
    in_valid = 1'b1; in_mode = 1'b1; in_data = 5'd1;
    step();
    in_data = 5'd2;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(out_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) step();

    // 65537 transfers wrap the counter to 1.
    in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_mode = i[0];
      in_data = W'(i * 7);
      step();
    end
    in_valid = 1'b0;
    repeat (S + 2) step();
    @(negedge clk);
    chk("cnt_wrap", 32'(out_cnt), 32'd1);
    step();

    // WIDTH=8: latency per STAGES and bin2gray/gray2bin round trip.
    for (int n = 0; n < 4; n++) begin
      x = 8'($urandom_range(0, 255));
      g = 8'(b2g_m(32'(x)));
      w8_send(1'b1, x);
      for (int k = 0; k < 3; k++) begin
        chk("w8_b2g_latency", 32'(lat8[k]), 32'(w8_stages(k)));
        chk("w8_b2g_data", 32'(res8[k]), 32'(g));
        chk("w8_b2g_mode", 32'(md8[k]), 32'd1);
      end
      w8_send(1'b0, g);
      for (int k = 0; k < 3; k++) begin
        chk("w8_g2b_latency", 32'(lat8[k]), 32'(w8_stages(k)));
        chk("w8_roundtrip", 32'(res8[k]), 32'(x));
        chk("w8_g2b_mode", 32'(md8[k]), 32'd0);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("w8_cnt", 32'(w8_cnt[k]), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
